// File: rtl/math_divider_seq_ctrl.sv
// Signed/unsigned request front-end for the unsigned iterative divider.
// Converts operands to magnitudes, sequences the divider, restores signs, and guards it with a watchdog.
module math_divider_seq_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_signed,
  input  logic [DATA_WIDTH-1:0] i_req_dividend,
  input  logic [DATA_WIDTH-1:0] i_req_divisor,
  output logic                  o_div_start,
  output logic [DATA_WIDTH-1:0] o_div_dividend,
  output logic [DATA_WIDTH-1:0] o_div_divisor,
  input  logic                  i_div_done,
  input  logic                  i_div_dbz,
  input  logic [DATA_WIDTH-1:0] i_div_quotient,
  input  logic [DATA_WIDTH-1:0] i_div_remainder,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_quotient,
  output logic [DATA_WIDTH-1:0] o_rsp_remainder,
  output logic                  o_rsp_dbz,
  output logic                  o_rsp_ovf,
  output logic                  o_rsp_timeout
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  // Timeout fires in the WAIT cycle whose increment would bring the counter to TIMEOUT_CYCLES-1.
  localparam logic [WD_WIDTH-1:0]   WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state_reg, state_next;

  logic                  ready_reg;
  logic                  signed_reg;
  logic [DATA_WIDTH-1:0] dividend_reg;
  logic [DATA_WIDTH-1:0] divisor_reg;
  logic [DATA_WIDTH-1:0] mag_dividend_reg;
  logic [DATA_WIDTH-1:0] mag_divisor_reg;
  logic                  neg_q_reg;
  logic                  neg_r_reg;
  logic [WD_WIDTH-1:0]   wd_reg;
  logic [DATA_WIDTH-1:0] rsp_q_reg;
  logic [DATA_WIDTH-1:0] rsp_r_reg;
  logic                  rsp_dbz_reg;
  logic                  rsp_ovf_reg;
  logic                  rsp_to_reg;

  logic                  accept;
  logic                  capture_done;
  logic                  capture_to;
  logic                  rsp_clear;
  logic                  dividend_neg;
  logic                  divisor_neg;
  logic [DATA_WIDTH-1:0] mag_dividend_next;
  logic [DATA_WIDTH-1:0] mag_divisor_next;
  logic [DATA_WIDTH-1:0] q_fix;
  logic [DATA_WIDTH-1:0] r_fix;
  logic                  ovf_cond;

  function automatic logic [DATA_WIDTH-1:0] neg2(input logic [DATA_WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign accept       = (state_reg == ST_IDLE) && ready_reg && i_req_valid;
  assign dividend_neg = i_req_signed && i_req_dividend[DATA_WIDTH-1];
  assign divisor_neg  = i_req_signed && i_req_divisor[DATA_WIDTH-1];

  // Negating MIN yields 2^(DATA_WIDTH-1), which is the correct unsigned magnitude.
  assign mag_dividend_next = dividend_neg ? neg2(i_req_dividend) : i_req_dividend;
  assign mag_divisor_next  = divisor_neg  ? neg2(i_req_divisor)  : i_req_divisor;

  assign q_fix    = neg_q_reg ? neg2(i_div_quotient)  : i_div_quotient;
  assign r_fix    = neg_r_reg ? neg2(i_div_remainder) : i_div_remainder;
  assign ovf_cond = signed_reg && (dividend_reg == MIN_VAL) && (divisor_reg == ALL_ONES);

  always_comb begin
    state_next   = state_reg;
    capture_done = 1'b0;
    capture_to   = 1'b0;
    rsp_clear    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_div_done) begin
          capture_done = 1'b1;
          state_next   = ST_RESP;
        end else if (wd_reg == WD_LAST) begin
          capture_to = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_clear  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ST_IDLE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      signed_reg       <= 1'b0;
      dividend_reg     <= '0;
      divisor_reg      <= '0;
      mag_dividend_reg <= '0;
      mag_divisor_reg  <= '0;
      neg_q_reg        <= 1'b0;
      neg_r_reg        <= 1'b0;
    end else if (accept) begin
      signed_reg       <= i_req_signed;
      dividend_reg     <= i_req_dividend;
      divisor_reg      <= i_req_divisor;
      mag_dividend_reg <= mag_dividend_next;
      mag_divisor_reg  <= mag_divisor_next;
      neg_q_reg        <= dividend_neg ^ divisor_neg;
      neg_r_reg        <= dividend_neg;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_reg <= '0;
    end else if (state_reg == ST_ISSUE) begin
      wd_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      wd_reg <= wd_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_q_reg   <= '0;
      rsp_r_reg   <= '0;
      rsp_dbz_reg <= 1'b0;
      rsp_ovf_reg <= 1'b0;
      rsp_to_reg  <= 1'b0;
    end else if (capture_done) begin
      // Divide-by-zero reports the raw dividend and skips sign restoration.
      if (i_div_dbz) begin
        rsp_q_reg   <= ALL_ONES;
        rsp_r_reg   <= dividend_reg;
        rsp_dbz_reg <= 1'b1;
        rsp_ovf_reg <= 1'b0;
      end else begin
        rsp_q_reg   <= q_fix;
        rsp_r_reg   <= r_fix;
        rsp_dbz_reg <= 1'b0;
        rsp_ovf_reg <= ovf_cond;
      end
      rsp_to_reg <= 1'b0;
    end else if (capture_to) begin
      rsp_q_reg   <= '0;
      rsp_r_reg   <= '0;
      rsp_dbz_reg <= 1'b0;
      rsp_ovf_reg <= 1'b0;
      rsp_to_reg  <= 1'b1;
    end else if (rsp_clear) begin
      rsp_q_reg   <= '0;
      rsp_r_reg   <= '0;
      rsp_dbz_reg <= 1'b0;
      rsp_ovf_reg <= 1'b0;
      rsp_to_reg  <= 1'b0;
    end
  end

  assign o_req_ready     = ready_reg;
  assign o_div_start     = (state_reg == ST_ISSUE);
  assign o_div_dividend  = mag_dividend_reg;
  assign o_div_divisor   = mag_divisor_reg;
  assign o_rsp_valid     = (state_reg == ST_RESP);
  assign o_rsp_quotient  = rsp_q_reg;
  assign o_rsp_remainder = rsp_r_reg;
  assign o_rsp_dbz       = rsp_dbz_reg;
  assign o_rsp_ovf       = rsp_ovf_reg;
  assign o_rsp_timeout   = rsp_to_reg;

endmodule

// File: tb/tb_math_divider_seq_ctrl.sv
// Directed bench for math_divider_seq_ctrl with a behavioural unsigned divider model.
module tb_math_divider_seq_ctrl;

  localparam int DW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_signed = 1'b0;
  logic [DW-1:0] req_dividend = '0;
  logic [DW-1:0] req_divisor = '0;
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_done = 1'b0;
  logic          div_dbz = 1'b0;
  logic [DW-1:0] div_q = '0;
  logic [DW-1:0] div_r = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_q;
  logic [DW-1:0] rsp_r;
  logic          rsp_dbz;
  logic          rsp_ovf;
  logic          rsp_to;

  int n_checks = 0;
  int n_errors = 0;

  math_divider_seq_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_signed    (req_signed),
    .i_req_dividend  (req_dividend),
    .i_req_divisor   (req_divisor),
    .o_div_start     (div_start),
    .o_div_dividend  (div_dividend),
    .o_div_divisor   (div_divisor),
    .i_div_done      (div_done),
    .i_div_dbz       (div_dbz),
    .i_div_quotient  (div_q),
    .i_div_remainder (div_r),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_quotient  (rsp_q),
    .o_rsp_remainder (rsp_r),
    .o_rsp_dbz       (rsp_dbz),
    .o_rsp_ovf       (rsp_ovf),
    .o_rsp_timeout   (rsp_to)
  );

  always #5 clk = ~clk;

  // Divider model: done one cycle after start for a zero divisor, DW cycles after start otherwise.
  logic          hang = 1'b0;
  logic          busy = 1'b0;
  int            lat_cnt = 0;
  int            start_cnt = 0;
  int            rsp_seen = 0;
  logic [DW-1:0] seen_a = '0;
  logic [DW-1:0] seen_b = '0;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;

  always @(posedge clk) begin
    div_done <= 1'b0;
    div_dbz  <= 1'b0;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
    if (rst) begin
      busy <= 1'b0;
    end else if (div_start) begin
      start_cnt <= start_cnt + 1;
      seen_a    <= div_dividend;
      seen_b    <= div_divisor;
      if (div_divisor == '0) begin
        if (!hang) begin
          div_done <= 1'b1;
          div_dbz  <= 1'b1;
          div_q    <= '1;
          div_r    <= div_dividend;
        end
      end else begin
        busy    <= 1'b1;
        lat_cnt <= DW - 1;
        m_a     <= div_dividend;
        m_b     <= div_divisor;
      end
    end else if (busy && !hang) begin
      if (lat_cnt == 0) begin
        div_done <= 1'b1;
        busy     <= 1'b0;
        div_q    <= m_a / m_b;
        div_r    <= m_a % m_b;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic sgn, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] eq, input logic [DW-1:0] er,
                        input logic edbz, input logic eovf, input logic eto, input int elat,
                        input logic [DW-1:0] eda, input logic [DW-1:0] edb, input int bp);
    int s0;
    int lat;
    s0 = start_cnt;
    chk({tag, "_ready"}, req_ready, 1);
    req_valid    = 1'b1;
    req_signed   = sgn;
    req_dividend = a;
    req_divisor  = b;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_dividend = 16'h1234;
    req_divisor  = 16'h0003;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, rsp_q, eq);
    chk({tag, "_r"}, rsp_r, er);
    chk({tag, "_flags"}, {rsp_dbz, rsp_ovf, rsp_to}, {edbz, eovf, eto});
    chk({tag, "_starts"}, start_cnt - s0, 1);
    chk({tag, "_div_a"}, seen_a, eda);
    chk({tag, "_div_b"}, seen_b, edb);
    chk({tag, "_busy_ready"}, req_ready, 0);
    if (bp > 0) req_valid = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({tag, "_bp_valid"}, rsp_valid, 1);
      chk({tag, "_bp_q"}, rsp_q, eq);
      chk({tag, "_bp_r"}, rsp_r, er);
      chk({tag, "_bp_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, "_drop_valid"}, rsp_valid, 0);
    chk({tag, "_clr_flags"}, {rsp_dbz, rsp_ovf, rsp_to}, 3'b000);
    chk({tag, "_idle_ready"}, req_ready, 1);
    chk({tag, "_one_start"}, start_cnt - s0, 1);
    $display("req %s: signed=%0d %h/%h -> q=%h r=%h dbz=%0d ovf=%0d to=%0d lat=%0d",
             tag, sgn, a, b, eq, er, edbz, eovf, eto, lat);
  endtask

  initial begin
    int s0;
    int r0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_start", div_start, 0);
    chk("rst_div_a", div_dividend, 0);
    chk("rst_rsp_q", rsp_q, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_ready_low", req_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_ready_high", req_ready, 1);

    do_req("u100_7",    1'b0, 16'd100, 16'd7,   16'd14,  16'd2,   0, 0, 0, DW + 3, 16'd100, 16'd7, 0);
    do_req("sm7_2",     1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 0, 0, DW + 3, 16'd7, 16'd2, 0);
    do_req("s7_m2",     1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 0, 0, 0, DW + 3, 16'd7, 16'd2, 0);
    do_req("sm7_m2",    1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 0, 0, 0, DW + 3, 16'd7, 16'd2, 0);
    do_req("s_ovf",     1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 0, DW + 3, 16'h8000, 16'h0001, 0);
    do_req("u5_0",      1'b0, 16'd5,   16'd0,   16'hFFFF, 16'h0005, 1, 0, 0, 3, 16'd5, 16'd0, 0);
    do_req("s5_0",      1'b1, 16'd5,   16'd0,   16'hFFFF, 16'h0005, 1, 0, 0, 3, 16'd5, 16'd0, 0);
    do_req("sm5_0",     1'b1, 16'hFFFB, 16'd0,  16'hFFFF, 16'hFFFB, 1, 0, 0, 3, 16'd5, 16'd0, 0);
    do_req("u_bp",      1'b0, 16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001, 0, 0, 0, DW + 3, 16'hFFFF, 16'h0002, 5);

    hang = 1'b1;
    do_req("timeout",   1'b0, 16'd9,   16'd3,   16'h0000, 16'h0000, 0, 0, 1, TO + 1, 16'd9, 16'd3, 0);

    // Reset while the divider is busy.
    req_valid    = 1'b1;
    req_signed   = 1'b0;
    req_dividend = 16'd50;
    req_divisor  = 16'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", req_ready, 0);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_start", div_start, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hang = 1'b0;
    s0 = start_cnt;
    r0 = rsp_seen;
    @(posedge clk); #1;
    chk("midrst_ready_after", req_ready, 1);
    repeat (80) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_seen - r0, 0);
    chk("midrst_no_start", start_cnt - s0, 0);

    do_req("recover",   1'b0, 16'd100, 16'd7,   16'd14,  16'd2,   0, 0, 0, DW + 3, 16'd100, 16'd7, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
